// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, operation
// encodings, write masks, CSR layouts and the Zicsr modify helper.
package csr_file_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_SATP      = 12'h180;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MEDELEG   = 12'h302;
    localparam logic [11:0] CSR_MIDELEG   = 12'h303;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Privilege encodings
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Writable bits: mstatus keeps mie(3), mpie(7), mpp(12:11); mie keeps MSIE/MTIE/MEIE
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_1888;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } req_state_e;

    typedef struct packed {
        logic       sd;
        logic [7:0] wpri23;
        logic       tsr;
        logic       tw;
        logic       tvm;
        logic       mxr;
        logic       sum;
        logic       mprv;
        logic [1:0] xs;
        logic [1:0] fs;
        logic [1:0] mpp;
        logic [1:0] wpri9;
        logic       spp;
        logic       mpie;
        logic       wpri6;
        logic       spie;
        logic       upie;
        logic       mie;
        logic       wpri2;
        logic       sie;
        logic       uie;
    } mstatus_t;

    typedef struct packed {
        logic [1:0]  mxl;
        logic [3:0]  wlrl;
        logic [25:0] ext;
    } misa_t;

    typedef struct packed {
        logic [29:0] base;
        logic [1:0]  mode;
    } mtvec_t;

    typedef struct packed {
        logic [19:0] wpri12;
        logic        meie;
        logic        wpri10;
        logic        seie;
        logic        ueie;
        logic        mtie;
        logic        wpri6;
        logic        stie;
        logic        utie;
        logic        msie;
        logic        wpri2;
        logic        ssie;
        logic        usie;
    } mie_t;

    typedef struct packed {
        logic [19:0] wpri12;
        logic        meip;
        logic        wpri10;
        logic        seip;
        logic        ueip;
        logic        mtip;
        logic        wpri6;
        logic        stip;
        logic        utip;
        logic        msip;
        logic        wpri2;
        logic        ssip;
        logic        usip;
    } mip_t;

    typedef struct packed {
        logic        mode;
        logic [8:0]  asid;
        logic [21:0] ppn;
    } satp_t;

    // Zicsr read-modify-write combine of the old value with the operand
    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        case (op)
            CSR_OP_RW: return wdata;
            CSR_OP_RS: return old_val | wdata;
            CSR_OP_RC: return old_val & ~wdata;
            default:   return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running cycle counter; a write to either half replaces that
// half and suppresses the increment for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;
    logic [63:0] count_inc;
    logic [1:0]  wr_en;

    assign wr_en = {wr_hi, wr_lo};

    // Increment path, wrapping silently from all-ones to zero
    always_comb begin
        count_inc = count_q + 64'd1;
    end

    // Each half either takes the write data, holds (other half written) or increments
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        assign count_d[gi*32 +: 32] = (|wr_en)
                                    ? (wr_en[gi] ? wdata : count_q[gi*32 +: 32])
                                    : count_inc[gi*32 +: 32];
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 64'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: serves Zicsr requests over valid/ready, commits
// trap entry and mret, and drives the fetch redirect.
module csr_file
    import csr_file_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [25:0] MISA_EXT    = 26'h0141101,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_req_valid,
    output logic            csr_req_ready,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic            csr_rsp_valid,
    input  logic            csr_rsp_ready,
    output logic [XLEN-1:0] csr_rsp_rdata,
    output logic            csr_rsp_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    output logic            irq_pending,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv_mode
);

    req_state_e  state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_illegal_q, rsp_illegal_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [1:0]  priv_q, priv_d;

    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [1:0]  mst_mpp_q, mst_mpp_d;
    mtvec_t      mtvec_q, mtvec_d;
    logic [31:0] medeleg_q, medeleg_d;
    logic [31:0] mideleg_q, mideleg_d;
    mie_t        mie_q, mie_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    satp_t       satp_q, satp_d;

    logic [63:0] mcycle;
    mstatus_t    mstatus_rd;
    mip_t        mip_rd;
    misa_t       misa_rd;
    csr_op_e     op;
    logic [31:0] old_val;
    logic [31:0] wval;
    logic        implemented;
    logic        wants_write;
    logic        illegal;
    logic        hide_rdata;
    logic        accept;
    logic        do_write;
    logic        cyc_wr_lo;
    logic        cyc_wr_hi;
    logic [31:0] trap_base;

    assign op = csr_op_e'(csr_op);

    // Readback views assembled from the stored fields and the interrupt lines
    always_comb begin
        mstatus_rd      = '0;
        mstatus_rd.mie  = mst_mie_q;
        mstatus_rd.mpie = mst_mpie_q;
        mstatus_rd.mpp  = mst_mpp_q;
        mip_rd          = '0;
        mip_rd.meip     = irq_meip;
        mip_rd.mtip     = irq_mtip;
        mip_rd.msip     = irq_msip;
        misa_rd         = '0;
        misa_rd.mxl     = 2'b01;
        misa_rd.ext     = MISA_EXT;
    end

    // Address decode: old value and whether the address exists
    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   old_val = mstatus_rd;
            CSR_MISA:      old_val = misa_rd;
            CSR_MEDELEG:   old_val = medeleg_q;
            CSR_MIDELEG:   old_val = mideleg_q;
            CSR_MIE:       old_val = mie_q;
            CSR_MTVEC:     old_val = mtvec_q;
            CSR_MSCRATCH:  old_val = mscratch_q;
            CSR_MEPC:      old_val = mepc_q;
            CSR_MCAUSE:    old_val = mcause_q;
            CSR_MTVAL:     old_val = mtval_q;
            CSR_MIP:       old_val = mip_rd;
            CSR_SATP:      old_val = satp_q;
            CSR_MCYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH:   old_val = mcycle[63:32];
            CSR_MVENDORID: old_val = 32'h0;
            CSR_MARCHID:   old_val = 32'h0;
            CSR_MIMPID:    old_val = 32'h0;
            CSR_MHARTID:   old_val = HART_ID;
            default:       implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero operand are pure reads, so they never fault on read-only CSRs
    always_comb begin
        wants_write = (op == CSR_OP_RW) ||
                      (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (csr_wdata != 32'h0));
        hide_rdata  = !implemented || (priv_q == PRIV_U);
        illegal     = hide_rdata || ((csr_addr[11:10] == 2'b11) && wants_write);
        accept      = csr_req_valid && csr_req_ready;
        do_write    = accept && !illegal && wants_write;
        wval        = csr_apply_op(op, old_val, csr_wdata);
        cyc_wr_lo   = do_write && (csr_addr == CSR_MCYCLE);
        cyc_wr_hi   = do_write && (csr_addr == CSR_MCYCLEH);
        trap_base   = {mtvec_q.base, 2'b00};
    end

    // Request handshake: accept only when idle and no commit event competes
    assign csr_req_ready = (state_q == ST_IDLE) && !trap_valid && !mret_valid;

    // Response FSM: capture old value on accept, hold until consumed
    always_comb begin
        state_d       = state_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = hide_rdata ? 32'h0 : old_val;
                    rsp_illegal_d = illegal;
                end
            end
            ST_RESP: begin
                if (csr_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural CSR updates: software writes, then trap entry / mret commits
    always_comb begin
        priv_d           = priv_q;
        mst_mie_d        = mst_mie_q;
        mst_mpie_d       = mst_mpie_q;
        mst_mpp_d        = mst_mpp_q;
        mtvec_d          = mtvec_q;
        medeleg_d        = medeleg_q;
        mideleg_d        = mideleg_q;
        mie_d            = mie_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        satp_d           = satp_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (do_write) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mst_mie_d  = wval[3];
                    mst_mpie_d = wval[7];
                    if (wval[12:11] != 2'b10) mst_mpp_d = wval[12:11];
                end
                CSR_MEDELEG:  medeleg_d  = wval;
                CSR_MIDELEG:  mideleg_d  = wval;
                CSR_MIE:      mie_d      = mie_t'(wval & MIE_WMASK);
                CSR_MTVEC: begin
                    mtvec_d.base = wval[31:2];
                    if (!wval[1]) mtvec_d.mode = wval[1:0];
                end
                CSR_MSCRATCH: mscratch_d = wval;
                CSR_MEPC:     mepc_d     = {wval[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = wval;
                CSR_MTVAL:    mtval_d    = wval;
                CSR_SATP:     satp_d     = satp_t'(wval);
                default: ;
            endcase
        end

        if (trap_valid) begin
            mepc_d           = {trap_epc[31:2], 2'b00};
            mcause_d         = trap_cause;
            mtval_d          = trap_tval;
            mst_mpie_d       = mst_mie_q;
            mst_mie_d        = 1'b0;
            mst_mpp_d        = priv_q;
            priv_d           = PRIV_M;
            redirect_valid_d = 1'b1;
            if ((mtvec_q.mode == 2'b01) && trap_cause[31])
                redirect_pc_d = trap_base + {trap_cause[29:0], 2'b00};
            else
                redirect_pc_d = trap_base;
        end else if (mret_valid) begin
            mst_mie_d        = mst_mpie_q;
            mst_mpie_d       = 1'b1;
            priv_d           = mst_mpp_q;
            mst_mpp_d        = PRIV_U;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = mepc_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= 32'h0;
            rsp_illegal_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            priv_q           <= PRIV_M;
            mst_mie_q        <= 1'b0;
            mst_mpie_q       <= 1'b0;
            mst_mpp_q        <= PRIV_M;
            mtvec_q          <= mtvec_t'(MTVEC_RESET);
            medeleg_q        <= 32'h0;
            mideleg_q        <= 32'h0;
            mie_q            <= '0;
            mscratch_q       <= 32'h0;
            mepc_q           <= 32'h0;
            mcause_q         <= 32'h0;
            mtval_q          <= 32'h0;
            satp_q           <= '0;
        end else begin
            state_q          <= state_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
            rsp_illegal_q    <= rsp_illegal_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            priv_q           <= priv_d;
            mst_mie_q        <= mst_mie_d;
            mst_mpie_q       <= mst_mpie_d;
            mst_mpp_q        <= mst_mpp_d;
            mtvec_q          <= mtvec_d;
            medeleg_q        <= medeleg_d;
            mideleg_q        <= mideleg_d;
            mie_q            <= mie_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            satp_q           <= satp_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .wr_lo (cyc_wr_lo),
        .wr_hi (cyc_wr_hi),
        .wdata (csr_wdata),
        .count (mcycle)
    );

    assign irq_pending     = (|(mip_rd & mie_q & MIE_WMASK)) && (mst_mie_q || (priv_q != PRIV_M));
    assign csr_rsp_valid   = rsp_valid_q;
    assign csr_rsp_rdata   = rsp_rdata_q;
    assign csr_rsp_illegal = rsp_illegal_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign priv_mode       = priv_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed CSR requests feed an expectation queue that a
// separate monitor drains as responses appear; commit-side outputs are
// checked inline.
module tb_csr_file;

    localparam logic [31:0] HART = 32'h0000_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_req_valid = 1'b0;
    logic        csr_req_ready;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h0;
    logic [31:0] csr_wdata = 32'h0;
    logic        csr_rsp_valid;
    logic        csr_rsp_ready = 1'b1;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_illegal;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = 32'h0;
    logic [31:0] trap_epc = 32'h0;
    logic [31:0] trap_tval = 32'h0;
    logic        mret_valid = 1'b0;
    logic        irq_msip = 1'b0;
    logic        irq_mtip = 1'b0;
    logic        irq_meip = 1'b0;
    logic        irq_pending;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  priv_mode;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_rdata_q[$];
    logic [31:0] exp_mask_q[$];
    logic        exp_ill_q[$];
    string       exp_name_q[$];

    always #5 clk = ~clk;

    csr_file #(
        .XLEN        (32),
        .HART_ID     (HART),
        .MISA_EXT    (26'h0141101),
        .MTVEC_RESET (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .csr_req_valid   (csr_req_valid),
        .csr_req_ready   (csr_req_ready),
        .csr_op          (csr_op),
        .csr_addr        (csr_addr),
        .csr_wdata       (csr_wdata),
        .csr_rsp_valid   (csr_rsp_valid),
        .csr_rsp_ready   (csr_rsp_ready),
        .csr_rsp_rdata   (csr_rsp_rdata),
        .csr_rsp_illegal (csr_rsp_illegal),
        .trap_valid      (trap_valid),
        .trap_cause      (trap_cause),
        .trap_epc        (trap_epc),
        .trap_tval       (trap_tval),
        .mret_valid      (mret_valid),
        .irq_msip        (irq_msip),
        .irq_mtip        (irq_mtip),
        .irq_meip        (irq_meip),
        .irq_pending     (irq_pending),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .priv_mode       (priv_mode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: one comparison per consumed response
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && csr_rsp_valid && csr_rsp_ready) begin
                total++;
                if (exp_rdata_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rsp: got rdata=%h ill=%0b with nothing expected",
                             csr_rsp_rdata, csr_rsp_illegal);
                end else begin
                    logic [31:0] er, em;
                    logic        ei;
                    string       en;
                    er = exp_rdata_q.pop_front();
                    em = exp_mask_q.pop_front();
                    ei = exp_ill_q.pop_front();
                    en = exp_name_q.pop_front();
                    if (((csr_rsp_rdata & em) !== (er & em)) || (csr_rsp_illegal !== ei)) begin
                        bad++;
                        $display("FAIL %s: got rdata=%h ill=%0b want rdata=%h ill=%0b (mask %h)",
                                 en, csr_rsp_rdata, csr_rsp_illegal, er, ei, em);
                    end
                    $display("rsp %s: rdata=%h ill=%0b", en, csr_rsp_rdata, csr_rsp_illegal);
                end
            end
        end
    end

    // Issue one request; starts and ends just after a rising edge
    task automatic do_csr(input string name, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_ill, input logic [31:0] mask = 32'hFFFF_FFFF);
        int n = 0;
        csr_req_valid = 1'b1;
        csr_op        = op;
        csr_addr      = addr;
        csr_wdata     = wdata;
        @(negedge clk);
        while (!csr_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!csr_req_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept: got ready=0 want ready=1 within 20 cycles", name);
            csr_req_valid = 1'b0;
            return;
        end
        exp_rdata_q.push_back(exp_rdata);
        exp_mask_q.push_back(mask);
        exp_ill_q.push_back(exp_ill);
        exp_name_q.push_back(name);
        @(posedge clk);
        #1;
        csr_req_valid = 1'b0;
    endtask

    // One-cycle trap and/or mret commit pulse
    task automatic commit_pulse(input logic t, input logic m, input logic [31:0] cause,
                                input logic [31:0] epc, input logic [31:0] tval);
        trap_valid = t;
        mret_valid = m;
        trap_cause = cause;
        trap_epc   = epc;
        trap_tval  = tval;
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        mret_valid = 1'b0;
    endtask

    // Redirect must be present now and gone one cycle later
    task automatic check_redirect(input string name, input logic [31:0] pc);
        check({name, "_rv"}, {31'b0, redirect_valid}, 32'd1);
        check({name, "_pc"}, redirect_pc, pc);
        @(posedge clk);
        #1;
        check({name, "_pulse"}, {31'b0, redirect_valid}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_rdata_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (exp_rdata_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d outstanding want 0", exp_rdata_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'b0, csr_rsp_valid}, 32'd0);
        check("rst_rsp_rdata", csr_rsp_rdata, 32'h0);
        check("rst_redir_v", {31'b0, redirect_valid}, 32'd0);
        check("rst_redir_pc", redirect_pc, 32'h0);
        check("rst_priv", {30'b0, priv_mode}, 32'd3);
        check("rst_irq", {31'b0, irq_pending}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Identification and reset values
        do_csr("rd_misa",    2'b00, 12'h301, 32'h0, 32'h4014_1101, 1'b0);
        do_csr("rd_mhartid", 2'b00, 12'hF14, 32'h0, HART, 1'b0);
        do_csr("rd_mstatus", 2'b00, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
        do_csr("rd_mtvec",   2'b00, 12'h305, 32'h0, 32'h0, 1'b0);

        // Vectored mtvec, enable mie, interrupt trap at M
        do_csr("rw_mtvec",   2'b01, 12'h305, 32'h8000_0101, 32'h0, 1'b0);
        do_csr("rs_mie_bit", 2'b10, 12'h300, 32'h8, 32'h0000_1800, 1'b0);
        drain();
        commit_pulse(1'b1, 1'b0, 32'h8000_0007, 32'h0000_1237, 32'h0000_DEAD);
        check_redirect("trap1", 32'h8000_011C);
        check("trap1_priv", {30'b0, priv_mode}, 32'd3);
        do_csr("rd_mepc1",   2'b00, 12'h341, 32'h0, 32'h0000_1234, 1'b0);
        do_csr("rd_mcause1", 2'b00, 12'h342, 32'h0, 32'h8000_0007, 1'b0);
        do_csr("rd_mtval1",  2'b00, 12'h343, 32'h0, 32'h0000_DEAD, 1'b0);
        do_csr("rd_mst1",    2'b00, 12'h300, 32'h0, 32'h0000_1880, 1'b0);

        // Clear mpp so mret drops to U
        do_csr("rc_mpp",     2'b11, 12'h300, 32'h1800, 32'h0000_1880, 1'b0);
        drain();
        commit_pulse(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        check_redirect("mret1", 32'h0000_1234);
        check("mret1_priv", {30'b0, priv_mode}, 32'd0);
        do_csr("u_rd_mst",   2'b00, 12'h300, 32'h0, 32'h0, 1'b1, 32'h0);
        do_csr("u_rw_mscr",  2'b01, 12'h340, 32'h1, 32'h0, 1'b1, 32'h0);
        drain();

        // Exception from U: vectored mode only applies to interrupts
        commit_pulse(1'b1, 1'b0, 32'h0000_0002, 32'h0000_2000, 32'h0);
        check_redirect("trap2", 32'h8000_0100);
        check("trap2_priv", {30'b0, priv_mode}, 32'd3);
        do_csr("rd_mst2",    2'b00, 12'h300, 32'h0, 32'h0000_0088 & 32'h0000_1888 & ~32'h8, 1'b0);
        do_csr("rd_mcause2", 2'b00, 12'h342, 32'h0, 32'h0000_0002, 1'b0);

        // Read-only and unimplemented addresses
        do_csr("rw_mvendor", 2'b01, 12'hF11, 32'h5, 32'h0, 1'b1);
        do_csr("rs0_mvendor",2'b10, 12'hF11, 32'h0, 32'h0, 1'b0);
        do_csr("rd_mvendor", 2'b00, 12'hF11, 32'h0, 32'h0, 1'b0);
        do_csr("rd_7c0",     2'b00, 12'h7C0, 32'h0, 32'h0, 1'b1);
        do_csr("rw_7c0",     2'b01, 12'h7C0, 32'h1234, 32'h0, 1'b1);

        // WARL fields
        do_csr("rw_mtvec_m3",2'b01, 12'h305, 32'h0000_2003, 32'h8000_0101, 1'b0);
        do_csr("rd_mtvec2",  2'b00, 12'h305, 32'h0, 32'h0000_2001, 1'b0);
        do_csr("rw_mst_all", 2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_0080, 1'b0);
        do_csr("rw_mst_pp10",2'b01, 12'h300, 32'h0000_1000, 32'h0000_1888, 1'b0);
        do_csr("rd_mst3",    2'b00, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
        do_csr("rw_mie_all", 2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0);
        do_csr("rd_mie",     2'b00, 12'h304, 32'h0, 32'h0000_0888, 1'b0);
        do_csr("rw_misa",    2'b01, 12'h301, 32'h0, 32'h4014_1101, 1'b0);
        do_csr("rd_misa2",   2'b00, 12'h301, 32'h0, 32'h4014_1101, 1'b0);
        do_csr("rw_mepc",    2'b01, 12'h341, 32'hFFFF_FFFF, 32'h0000_2000, 1'b0);
        do_csr("rd_mepc2",   2'b00, 12'h341, 32'h0, 32'hFFFF_FFFC, 1'b0);
        do_csr("rw_satp",    2'b01, 12'h180, 32'h8123_4567, 32'h0, 1'b0);
        do_csr("rd_satp",    2'b00, 12'h180, 32'h0, 32'h8123_4567, 1'b0);

        // Response held for 3 cycles, with simultaneous trap+mret meanwhile
        do_csr("rw_mscr",    2'b01, 12'h340, 32'hCAFE_F00D, 32'h0, 1'b0);
        do_csr("rd_mscr_hold", 2'b00, 12'h340, 32'h0, 32'hCAFE_F00D, 1'b0);
        csr_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_ready", {31'b0, csr_req_ready}, 32'd0);
            check("hold_rdata", csr_rsp_rdata, 32'hCAFE_F00D);
            @(posedge clk);
            #1;
        end
        commit_pulse(1'b1, 1'b1, 32'h0000_000B, 32'h0000_3000, 32'h0000_0011);
        check("both_rsp_valid", {31'b0, csr_rsp_valid}, 32'd1);
        check("both_rsp_rdata", csr_rsp_rdata, 32'hCAFE_F00D);
        check_redirect("both", 32'h0000_2000);
        csr_rsp_ready = 1'b1;
        drain();
        do_csr("rd_mst4",    2'b00, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
        do_csr("rd_mepc3",   2'b00, 12'h341, 32'h0, 32'h0000_3000, 1'b0);
        do_csr("rd_mcause3", 2'b00, 12'h342, 32'h0, 32'h0000_000B, 1'b0);
        check("both_priv", {30'b0, priv_mode}, 32'd3);

        // mcycle carry into the high half
        do_csr("rw_mcych",   2'b01, 12'hB80, 32'h0, 32'h0, 1'b0);
        do_csr("rw_mcyc",    2'b01, 12'hB00, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0);
        do_csr("rd_mcych",   2'b00, 12'hB80, 32'h0, 32'h0000_0001, 1'b0);
        do_csr("rd_mcyc",    2'b00, 12'hB00, 32'h0, 32'h0000_0002, 1'b0);

        // Interrupt pending
        do_csr("rw_mie_mt",  2'b01, 12'h304, 32'h80, 32'h0000_0888, 1'b0);
        do_csr("rs_mst_mie", 2'b10, 12'h300, 32'h8, 32'h0000_1800, 1'b0);
        irq_mtip = 1'b1;
        @(negedge clk);
        check("irq_mtip", {31'b0, irq_pending}, 32'd1);
        do_csr("rd_mip",     2'b00, 12'h344, 32'h0, 32'h80, 1'b0);
        do_csr("rw_mip",     2'b01, 12'h344, 32'hFFFF_FFFF, 32'h80, 1'b0);
        do_csr("rd_mip2",    2'b00, 12'h344, 32'h0, 32'h80, 1'b0);
        irq_mtip = 1'b0;
        irq_msip = 1'b1;
        @(negedge clk);
        check("irq_msip_off", {31'b0, irq_pending}, 32'd0);
        irq_msip = 1'b0;
        irq_mtip = 1'b1;
        do_csr("rc_mst_mie", 2'b11, 12'h300, 32'h8, 32'h0000_1808, 1'b0);
        @(negedge clk);
        check("irq_gmie_off", {31'b0, irq_pending}, 32'd0);
        irq_mtip = 1'b0;
        drain();

        // Reset with a response outstanding
        csr_rsp_ready = 1'b0;
        do_csr("rd_lost",    2'b00, 12'h340, 32'h0, 32'hCAFE_F00D, 1'b0);
        rst = 1'b1;
        #2;
        check("rst_mid_valid", {31'b0, csr_rsp_valid}, 32'd0);
        check("rst_mid_priv", {30'b0, priv_mode}, 32'd3);
        exp_rdata_q.delete();
        exp_mask_q.delete();
        exp_ill_q.delete();
        exp_name_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        csr_rsp_ready = 1'b1;
        do_csr("rd_mscr_rst", 2'b00, 12'h340, 32'h0, 32'h0, 1'b0);
        do_csr("rd_mtvec_rst",2'b00, 12'h305, 32'h0, 32'h0, 1'b0);
        do_csr("rd_mst_rst",  2'b00, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
        do_csr("rd_mie_rst",  2'b00, 12'h304, 32'h0, 32'h0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file: holds the architectural CSR state whose layouts are the shared CSR typedefs (mstatus_t, misa_t, mtvec_t, mie_t, mip_t, satp_t, …).
- Serves Zicsr read/modify/write requests from the execute stage over a valid/ready handshake.
- Commits trap entry and mret, and returns the redirect PC to fetch.
- Sits beside the execute/commit stage and is the single writer of all M-mode CSRs.

Parameters:
XLEN, 32, register width; only 32 is supported.
HART_ID, 0, value returned by mhartid.
MISA_EXT, 26'h0141101, misa extension bits (A, I, M, S, U); read-only.
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
csr_req_valid  in  1  CSR request valid
csr_req_ready  out  1  CSR request accepted when valid&ready
csr_op  in  2  00 none/read, 01 RW, 10 RS (set), 11 RC (clear)
csr_addr  in  12  CSR address
csr_wdata  in  32  rs1/zimm operand
csr_rsp_valid  out  1  response valid
csr_rsp_ready  in  1  response consumed
csr_rsp_rdata  out  32  old CSR value
csr_rsp_illegal  out  1  illegal-instruction indication
trap_valid  in  1  commit trap this cycle
trap_cause  in  32  mcause value; bit31 = interrupt
trap_epc  in  32  faulting PC
trap_tval  in  32  mtval value
mret_valid  in  1  commit mret this cycle
irq_msip / irq_mtip / irq_meip  in  1 each  interrupt lines
irq_pending  out  1  enabled interrupt pending
redirect_valid  out  1  fetch redirect, one-cycle pulse
redirect_pc  out  32  redirect target
priv_mode  out  2  current privilege (11 M, 00 U)

Behaviour:
- Reset values:
  - csr_rsp_valid, csr_rsp_rdata, csr_rsp_illegal, redirect_valid, redirect_pc: 0.
  - priv_mode = 11.
  - mstatus = 0, with mpp = 11.
  - mtvec = MTVEC_RESET.
  - mcycle = 0.
  - All other writable CSRs = 0.
- Request FSM has two states, IDLE and RESP.
  - csr_req_ready = (state==IDLE) & !trap_valid & !mret_valid.
  - On accept: capture old value into csr_rsp_rdata, perform the write at the same edge, go to RESP. Latency is 1 cycle.
  - RESP holds rdata/illegal stable until csr_rsp_ready, then returns to IDLE.
  - No back-to-back accept: throughput is 1 per 2 cycles.
- Write value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
  - op 00: no write.
  - RS/RC with wdata==0: no write, and no illegal for read-only CSRs.
- Illegal:
  - Unimplemented address: illegal=1, rdata=0, no state change.
  - Write attempt to a read-only CSR (addr[11:10]==11): illegal=1, no state change.
  - Access while priv_mode==00: illegal=1.
- Implemented addresses:
  - 0x300 mstatus, 0x301 misa, 0x302 medeleg, 0x303 mideleg, 0x304 mie, 0x305 mtvec.
  - 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip.
  - 0x180 satp.
  - 0xB00 mcycle, 0xB80 mcycleh.
  - 0xF11 mvendorid (0), 0xF12 marchid (0), 0xF13 mimpid (0), 0xF14 mhartid.
- WARL rules:
  - mstatus: only mie, mpie, mpp are writable; mpp write of 10 keeps the old value; all other bits read 0.
  - misa: writes ignored, no illegal.
  - mtvec: mode write of 10 or 11 keeps the old mode.
  - mepc: bits[1:0] read 0.
  - mie: only bits 3, 7, 11 writable.
  - mip: reads {meip,mtip,msip} at bits 11/7/3; writes ignored.
  - satp: all fields stored.
- mcycle:
  - 64-bit counter, +1 every cycle.
  - A CSR write to mcycle/mcycleh in a cycle replaces that half; the increment is skipped that cycle.
  - Wrap from all-ones to 0 is silent.
- Trap entry (trap_valid):
  - mepc <= trap_epc & ~3; mcause <= trap_cause; mtval <= trap_tval.
  - mpie <= mie; mie <= 0; mpp <= priv_mode; priv_mode <= 11.
  - Next cycle: redirect_valid=1.
  - redirect_pc = {base,2'b00}, or, when mode==01 and cause[31]=1, {base,2'b00} + 4*cause[30:0].
- mret (mret_valid):
  - mie <= mpie; mpie <= 1; priv_mode <= mpp; mpp <= 00.
  - Next cycle: redirect to the current mepc.
- Simultaneous trap_valid and mret_valid: trap wins and mret is dropped.
- Trap/mret while in RESP: the pending response completes unchanged.
- irq_pending (combinational) = |(mip & mie & 0x888) & (mstatus.mie | priv_mode!=11).
- Reset mid-transaction: asynchronous clear to reset values; any pending response is discarded.

Decomposition:
- register_pkg additions:
  - CSR address localparams.
  - csr_op_e enum.
  - CSR write masks: MSTATUS_WMASK, MIE_WMASK = 32'h888.
  - Reuse the existing CSR typedefs for storage.
- One sub-module: csr_counter64, the mcycle counter with split write-enables.

Test Plan:
- Reset release; read 0x301 -> rdata=32'h4014_1101, illegal=0; read 0xF14 -> rdata=HART_ID.
- RW mtvec=32'h8000_0101, then trap cause=32'h8000_0007 -> redirect_pc=32'h8000_011C one cycle after; mepc=trap_epc&~3; mstatus.mie=0, mpie=old mie.
- Set mstatus.mie=1; trap at priv 11; mret -> mie=1, mpie=1, mpp=00, priv_mode=00, redirect_pc=mepc; CSR read at priv 00 -> illegal=1.
- RW 0xF11 with wdata=5 -> illegal=1, no change; RS 0xF11 with wdata=0 -> illegal=0; access to 0x7C0 -> illegal=1, rdata=0.
- Hold csr_rsp_ready=0 for 3 cycles -> csr_req_ready=0 and rdata stable throughout; trap_valid and mret_valid in the same cycle -> trap semantics only.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0 -> two cycles later mcycleh=1, mcycle=1; enable mie.MTIP with mstatus.mie=1, assert irq_mtip -> irq_pending=1.
